// File: rtl/uart_rx_framed.sv
// Configurable-frame oversampling UART receiver: 5..MaxDataBits data bits,
// optional even/odd parity, 1 or 2 stop bits, with false-start, break and resync detection.
module uart_rx_framed #(
    parameter int Oversample  = 16,
    parameter int MaxDataBits = 9
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   en,
    input  logic                   in,
    input  logic [3:0]             cfgDataBits,
    input  logic [1:0]             cfgParity,
    input  logic                   cfgStop2,
    output logic [MaxDataBits-1:0] data,
    output logic                   done,
    output logic                   parityErr,
    output logic                   frameErr,
    output logic                   syncErr,
    output logic                   breakDet
);
    localparam int CW = $clog2(Oversample);
    localparam logic [CW-1:0] CntTop = CW'(Oversample - 1);
    localparam logic [CW-1:0] CntMid = CW'(Oversample / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} stateT;

    stateT                  state;
    logic                   cmp;
    logic [CW-1:0]          sampleCount;
    logic [3:0]             bitCnt;
    logic [3:0]             nBits;
    logic [3:0]             cfgBitsEff;
    logic [MaxDataBits-1:0] shiftReg;
    logic                   parEn;
    logic                   parOdd;
    logic                   stop2;
    logic                   parBit;
    logic                   stopLow;
    logic                   edgeSeen;

    logic fall, rise, lineEdge, lateEdge, midPoint, bitEnd, lastStop, isBreak;

    always_comb begin
        cfgBitsEff = cfgDataBits;
        if (cfgDataBits < 4'd5)
            cfgBitsEff = 4'd5;
        else if (cfgDataBits > 4'(MaxDataBits))
            cfgBitsEff = 4'(MaxDataBits);
    end

    assign fall     = en && !in && cmp;
    assign rise     = en && in && !cmp;
    assign lineEdge = fall || rise;
    assign lateEdge = sampleCount >= CntMid;
    assign midPoint = sampleCount == CntMid;
    // An edge in the second half of a bit is the next bit arriving early.
    assign bitEnd   = (sampleCount == '0) || (lineEdge && !lateEdge);
    assign lastStop = (state == STOP2) || !stop2;
    assign isBreak  = !in && (shiftReg == '0) && !parBit;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            cmp         <= 1'b1;
            sampleCount <= CntTop;
            bitCnt      <= '0;
            nBits       <= 4'd5;
            shiftReg    <= '0;
            parEn       <= 1'b0;
            parOdd      <= 1'b0;
            stop2       <= 1'b0;
            parBit      <= 1'b0;
            stopLow     <= 1'b0;
            edgeSeen    <= 1'b0;
            data        <= '0;
            done        <= 1'b0;
            parityErr   <= 1'b0;
            frameErr    <= 1'b0;
            syncErr     <= 1'b0;
            breakDet    <= 1'b0;
        end else begin
            done      <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            syncErr   <= 1'b0;
            breakDet  <= 1'b0;
            if (en) begin
                cmp <= in;
                case (state)
                    IDLE: begin
                        if (fall) begin
                            state       <= START;
                            sampleCount <= CntTop;
                            edgeSeen    <= 1'b0;
                            bitCnt      <= '0;
                            shiftReg    <= '0;
                            parBit      <= 1'b0;
                            stopLow     <= 1'b0;
                            nBits       <= cfgBitsEff;
                            parEn       <= (cfgParity == 2'd1) || (cfgParity == 2'd2);
                            parOdd      <= cfgParity == 2'd2;
                            stop2       <= cfgStop2;
                        end
                    end
                    BREAK: begin
                        if (rise)
                            state <= IDLE;
                    end
                    default: begin
                        if (state == START && midPoint && in) begin
                            state       <= IDLE;
                            sampleCount <= CntTop;
                        end else if (lineEdge && lateEdge && edgeSeen) begin
                            syncErr     <= 1'b1;
                            state       <= IDLE;
                            sampleCount <= CntTop;
                        end else begin
                            sampleCount <= sampleCount - CW'(1);
                            if (lineEdge && lateEdge)
                                edgeSeen <= 1'b1;
                            if (midPoint) begin
                                case (state)
                                    DATA: begin
                                        for (int unsigned i = 0; i < MaxDataBits; i++)
                                            if (bitCnt == 4'(i))
                                                shiftReg[i] <= in;
                                        bitCnt <= bitCnt + 4'd1;
                                    end
                                    PARITY: parBit <= in;
                                    STOP1, STOP2: begin
                                        if (isBreak) begin
                                            breakDet    <= 1'b1;
                                            state       <= BREAK;
                                            sampleCount <= CntTop;
                                        end else if (lastStop) begin
                                            data        <= shiftReg;
                                            done        <= 1'b1;
                                            frameErr    <= stopLow || !in;
                                            parityErr   <= parEn && ((^shiftReg ^ parBit) != parOdd);
                                            state       <= IDLE;
                                            sampleCount <= CntTop;
                                        end else begin
                                            stopLow <= stopLow || !in;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            if (bitEnd) begin
                                sampleCount <= CntTop;
                                edgeSeen    <= 1'b0;
                                case (state)
                                    START:   state <= DATA;
                                    DATA:    if (bitCnt == nBits) state <= parEn ? PARITY : STOP1;
                                    PARITY:  state <= STOP1;
                                    STOP1:   state <= STOP2;
                                    default: state <= IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: a frame-level model predicts each
// done/break/sync event, and a monitor pops and compares whenever a pulse appears.
module tb_uart_rx_framed;
    localparam int Os  = 16;
    localparam int Mdb = 9;

    logic           clk = 1'b0;
    logic           nReset = 1'b0;
    logic           en = 1'b0;
    logic           rxLine = 1'b1;
    logic [3:0]     cfgDataBits = 4'd8;
    logic [1:0]     cfgParity = 2'd0;
    logic           cfgStop2 = 1'b0;
    logic [Mdb-1:0] data;
    logic           done, parityErr, frameErr, syncErr, breakDet;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned tickNum = 0;
    bit          enGaps = 1'b0;

    typedef enum {EvDone, EvBreak, EvSync} evKindT;
    typedef struct {
        evKindT      kind;
        logic [8:0]  data;
        logic        pErr;
        logic        fErr;
        int unsigned startTick;
        int unsigned latency;
    } expT;

    expT expQ[$];

    always #5 clk = ~clk;

    uart_rx_framed #(.Oversample(Os), .MaxDataBits(Mdb)) dut (
        .clk(clk), .nReset(nReset), .en(en), .in(rxLine),
        .cfgDataBits(cfgDataBits), .cfgParity(cfgParity), .cfgStop2(cfgStop2),
        .data(data), .done(done), .parityErr(parityErr), .frameErr(frameErr),
        .syncErr(syncErr), .breakDet(breakDet)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    expT         monE;
    int unsigned monDt;
    always @(posedge clk) begin
        #1;
        if (nReset && (done || breakDet || syncErr)) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected pulse: done=%b break=%b sync=%b data=0x%0h, no event expected",
                         done, breakDet, syncErr, data);
            end else begin
                monE = expQ.pop_front();
                check("event kind {done,break,sync}", {29'd0, done, breakDet, syncErr},
                      monE.kind == EvDone ? 32'd4 : (monE.kind == EvBreak ? 32'd2 : 32'd1));
                if (monE.kind == EvDone) begin
                    check("data", {23'd0, data}, {23'd0, monE.data});
                    check("parityErr/frameErr", {30'd0, parityErr, frameErr}, {30'd0, monE.pErr, monE.fErr});
                    monDt = tickNum - monE.startTick;
                    tests++;
                    if (monDt + 1 < monE.latency || monDt > monE.latency + 1) begin
                        fails++;
                        $display("FAIL done latency: got %0d ticks, required %0d +/-1", monDt, monE.latency);
                    end
                end
            end
        end
    end

    // One oversample tick, optionally preceded by idle (en=0) cycles.
    task automatic tick();
        int unsigned gap;
        gap = enGaps ? $urandom_range(0, 2) : 0;
        repeat (gap) begin
            en = 1'b0;
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        tickNum++;
        en = 1'b0;
    endtask

    task automatic sendBits(input logic v, input int unsigned nTicks);
        rxLine = v;
        repeat (nTicks) tick();
    endtask

    function automatic int effBits(input int raw);
        return raw < 5 ? 5 : (raw > Mdb ? Mdb : raw);
    endfunction

    task automatic sendFrame(input logic [8:0] word, input int rawBits, input int par, input bit s2,
                             input bit flip, input bit [1:0] stopLow, input int unsigned idle);
        int   n, ones, nStops;
        bit   parEn, pbit;
        logic [8:0] w;
        expT  e;
        n = effBits(rawBits);
        w = '0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            w[i] = word[i];
            ones += int'(word[i]);
        end
        parEn  = (par == 1) || (par == 2);
        pbit   = parEn ? (((ones % 2) == 1) ^ (par == 2) ^ flip) : 1'b0;
        nStops = s2 ? 2 : 1;
        e.kind = EvDone;
        e.data = w;
        e.pErr = parEn && ((((ones + int'(pbit)) % 2) == 1) != (par == 2));
        e.fErr = 1'b0;
        for (int i = 0; i < nStops; i++) begin
            if (stopLow[i]) begin
                if (w == 0 && !pbit) begin
                    e.kind = EvBreak;
                    break;
                end
                e.fErr = 1'b1;
            end
        end
        e.latency   = (1 + n + int'(parEn) + nStops) * Os - Os / 2;
        cfgDataBits = 4'(rawBits);
        cfgParity   = 2'(par);
        cfgStop2    = s2;
        e.startTick = tickNum;
        expQ.push_back(e);
        sendBits(1'b0, Os);
        for (int i = 0; i < n; i++) sendBits(w[i], Os);
        if (parEn) sendBits(pbit, Os);
        for (int i = 0; i < nStops; i++) sendBits(!stopLow[i], Os);
        sendBits(1'b1, idle);
    endtask

    task automatic checkOutputsClear(input string name);
        check(name, {17'd0, data, done, parityErr, frameErr, syncErr, breakDet}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", expQ.size());
        $fatal(1, "watchdog");
    end

    initial begin
        expT e;
        repeat (3) @(negedge clk);
        checkOutputsClear("reset outputs");
        nReset = 1'b1;
        sendBits(1'b1, 8);

        // 8N1 0xA5
        sendFrame(9'h0A5, 8, 0, 1'b0, 1'b0, 2'b00, 10);
        // 7E1 0x41 wrong then right parity
        sendFrame(9'h041, 7, 1, 1'b0, 1'b1, 2'b00, 10);
        sendFrame(9'h041, 7, 1, 1'b0, 1'b0, 2'b00, 10);
        // 8N2, second stop low
        sendFrame(9'h03C, 8, 0, 1'b1, 1'b0, 2'b10, 10);

        // Start glitch: 4 ticks low then high must produce nothing
        sendBits(1'b0, 4);
        sendBits(1'b1, 3 * Os);
        sendFrame(9'h055, 8, 0, 1'b0, 1'b0, 2'b00, 10);

        // Line low for 20 bit times in 8N1: single break, then 0xFF
        cfgDataBits = 4'd8; cfgParity = 2'd0; cfgStop2 = 1'b0;
        e = '{kind: EvBreak, data: 9'h0, pErr: 1'b0, fErr: 1'b0, startTick: 0, latency: 0};
        expQ.push_back(e);
        sendBits(1'b0, 20 * Os);
        sendBits(1'b1, 2 * Os);
        sendFrame(9'h0FF, 8, 0, 1'b0, 1'b0, 2'b00, 10);

        // Two late edges inside data bit 0: syncErr, frame dropped
        e = '{kind: EvSync, data: 9'h0, pErr: 1'b0, fErr: 1'b0, startTick: 0, latency: 0};
        expQ.push_back(e);
        sendBits(1'b0, Os);
        sendBits(1'b1, 2);
        sendBits(1'b0, 2);
        sendBits(1'b1, 12 * Os);
        sendFrame(9'h0C3, 8, 0, 1'b0, 1'b0, 2'b00, 10);

        // Config clamping: 3 -> 5 bits, 15 -> 9 bits
        sendFrame(9'h1F6, 3, 2, 1'b0, 1'b0, 2'b00, 10);
        sendFrame(9'h1A5, 15, 3, 1'b1, 1'b0, 2'b00, 10);

        // Randomized frames, some with en gaps
        for (int k = 0; k < 40; k++) begin
            logic [8:0] w;
            bit [1:0]   sl;
            enGaps = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 7) == 0) ? 9'h0 : 9'($urandom);
            sl[0] = ($urandom_range(0, 5) == 0);
            sl[1] = ($urandom_range(0, 5) == 0);
            sendFrame(w, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), sl,
                      $urandom_range(1, 24));
        end
        enGaps = 1'b0;

        // 9O1 back-to-back, then reset mid-way through a third frame
        sendFrame(9'h1FF, 9, 2, 1'b0, 1'b0, 2'b00, 0);
        sendFrame(9'h100, 9, 2, 1'b0, 1'b0, 2'b00, 4);
        sendBits(1'b0, Os);
        sendBits(1'b1, 5 * Os);
        nReset = 1'b0;
        rxLine = 1'b1;
        repeat (2) @(negedge clk);
        checkOutputsClear("outputs after mid-frame reset");
        nReset = 1'b1;
        sendBits(1'b1, 16 * Os);

        check("scoreboard drained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Configurable-frame UART receiver, the parametrised successor to the fixed 8N1 oversampling receiver. It decodes 5–`MaxDataBits` data bits, optional even/odd parity and 1 or 2 stop bits, all selectable at run time. It also flags false starts, break conditions and resynchronisation failures. It sits behind the shared baud-tick generator: `en` is the oversample tick, and `in` is an already-synchronised serial line.

## Interface
- `Oversample`, default 16: `en` ticks per bit; ≥4, even.
- `MaxDataBits`, default 9: width of `data`; 5..9.
- `clk`  in  1  sole clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `en`  in  1  oversample tick; all state advances only when 1.
- `in`  in  1  serial line, idle high.
- `cfgDataBits`  in  4  data bits per frame; values <5 are treated as 5, values >`MaxDataBits` as `MaxDataBits`.
- `cfgParity`  in  2  0 none, 1 even, 2 odd, 3 none.
- `cfgStop2`  in  1  1 = two stop bits.
- `data`  out  `MaxDataBits`  last received word, LSB-aligned, unused upper bits 0.
- `done`  out  1  frame-complete pulse.
- `parityErr`  out  1  parity mismatch; valid with `done`.
- `frameErr`  out  1  stop bit sampled low; valid with `done`.
- `syncErr`  out  1  frame aborted on a bad edge; no `done`.
- `breakDet`  out  1  break detected; no `done`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- Config is latched on the IDLE→START transition and held for the whole frame.
- Edge detection: `cmp` register, reset 1, loads `in` when `en`=1. Fall = `!in && cmp`, rise = `in && !cmp`, qualified by `en`.
- Bit timer `sampleCount` (width `$clog2(Oversample)`):
  - loads `Oversample-1` on every state or bit change;
  - decrements on each `en`;
  - mid-sample point: `sampleCount == Oversample/2`;
  - end of bit: `sampleCount == 0` with `en`.
- IDLE: fall → START.
- START: at mid-sample, `in`=1 is a false start → IDLE with no flags; otherwise continue, and at end of bit → DATA.
- DATA: shift `in` in LSB-first at each mid-sample. After `cfgDataBits` bits, at end of bit → PARITY if parity enabled, else STOP1.
- PARITY: sample at mid-sample. For even parity, the ones-count of data plus the parity bit must be even; for odd parity it must be odd. At end of bit → STOP1.
- STOP1/STOP2: sample at mid-sample.
  - Low stop bit, with all data bits 0 and the parity bit 0 (or absent) → pulse `breakDet`, enter BREAK, no `done`.
  - Low stop bit otherwise → `frameErr`.
  - Frame ends at the mid-sample of the final stop bit (STOP2 when `cfgStop2`, else STOP1). On that edge, register `data`, pulse `done` with `parityErr`/`frameErr`, and go directly to IDLE. An immediately following start edge is therefore accepted.
  - STOP1 → STOP2 occurs at end of bit. A low STOP1 still sets `frameErr`, which is reported with `done`.
- BREAK: wait for rise → IDLE.
- Resync, in START/DATA/PARITY/STOP:
  - An edge with `sampleCount < Oversample/2` is treated as an early next bit. The bit timer reloads immediately and the state advances as if at end of bit.
  - The first edge with `sampleCount ≥ Oversample/2` in a bit is tolerated.
  - A second such edge in the same bit pulses `syncErr` and forces IDLE. `data` is unchanged.
- `data` is written only on `done`.

## Timing
- Reset values: `data`=0; `done`, `parityErr`, `frameErr`, `syncErr`, `breakDet` all 0; state IDLE; `sampleCount`=`Oversample-1`; `cmp`=1.
- All outputs are registered. Each pulse is high for exactly one `clk` cycle following the qualifying `en` edge, regardless of `en` in that cycle.
- Latency: `done` rises the cycle after the `en` edge at the final stop mid-sample. That is (1 + bits + parity + stops − 0.5)·`Oversample` ticks after the start fall, ±1 tick.
- `en`=0 freezes all state except pulse deassertion.
- `nReset` asserted mid-frame: all state returns to reset values immediately and the partial frame is discarded.
- Simultaneous events: `syncErr` takes priority over a mid-sample in the same cycle; false start takes priority over resync.

## Test plan
- 8N1, `en` every cycle, Oversample 16, send 0xA5 → `done` pulse, `data`=0x0A5, all error flags 0.
- 7E1, send 0x41 with parity bit 1 (wrong) → `done` with `parityErr`=1, `data`=0x041. Same frame with parity 0 → `parityErr`=0.
- 8N2, second stop bit driven low, byte 0x3C → `done`, `frameErr`=1, `data`=0x03C.
- Start-bit glitch low for 4 ticks, then high → no pulses, state back in IDLE. A valid 0x55 frame that follows is received correctly.
- Line held low for 20 bit times in 8N1 → single `breakDet` pulse, no `done`. After the line rises, a following 0xFF frame gives `done`, `data`=0x0FF.
- Two back-to-back 9-bit odd-parity frames 0x1FF, 0x100, with `nReset` pulsed mid-way through a third frame → two `done` pulses with the correct data. After reset, all outputs are 0 and no third `done` occurs.
